alu_issue_stage: RTL
====================

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as listed below.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_reset  input  1  asynchronous, active-high reset.
REQ-004 i_valid  input  1  upstream (decode) presents an instruction.
REQ-005 o_ready  output  1  stage can accept an instruction this cycle.
REQ-006 i_pc, i_rs1_data, i_rs2_data, i_imm  input  32 each  PC, register-file read data, sign-extended immediate.
REQ-007 i_rs1_addr, i_rs2_addr, i_rd_addr  input  5 each  source and destination register indices.
REQ-008 i_alu_op  input  4  ALU op encoding: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
REQ-009 i_opa_sel  input  1  operand A source: 0 = rs1, 1 = pc.
REQ-010 i_opb_sel  input  1  operand B source: 0 = rs2, 1 = imm.
REQ-011 i_rd_wren  input  1  instruction writes rd.
REQ-012 i_fwd_wren, i_fwd_addr[4:0], i_fwd_data[31:0]  input  writeback bypass (write enable, index, data).
REQ-013 i_flush  input  1  kill the held instruction and any instruction offered this cycle.
REQ-014 o_valid  output  1  held instruction is valid for the ALU.
REQ-015 i_ready  input  1  downstream (ALU/EX) consumes the held instruction.
REQ-016 o_operand_a, o_operand_b  output  32 each  ALU operands.
REQ-017 o_alu_op  output  4  registered i_alu_op.
REQ-018 o_rs2_data  output  32  forwarded rs2 value (store data).
REQ-019 o_rd_addr  output  5  registered rd index.
REQ-020 o_rd_wren  output  1  registered rd write enable.

Function
REQ-021 The stage SHALL be a single-entry register stage; o_ready = !o_valid | i_ready (combinational).
REQ-022 Load condition: i_valid & o_ready & !i_flush; on load, the stage SHALL capture all inputs and set o_valid = 1 the next cycle.
REQ-023 Consume condition: o_valid & i_ready with no load; o_valid SHALL become 0 next cycle.
REQ-024 Simultaneous consume and load SHALL replace the entry with no bubble (o_valid stays 1).
REQ-025 i_flush SHALL have priority over all other events: o_valid = 0 next cycle, the offered instruction is dropped, and no stored field changes.
REQ-026 Load bypass: if i_fwd_wren & i_fwd_addr != 0 & i_fwd_addr == i_rsN_addr, the stage SHALL capture i_fwd_data instead of i_rsN_data (N = 1, 2).
REQ-027 Hold bypass: while o_valid & !i_ready & no load, a matching writeback (same rule as REQ-026) SHALL overwrite the stored rsN value.
REQ-028 Index 0 SHALL never be forwarded; a write to x0 leaves operands unchanged.
REQ-029 o_operand_a = stored opa_sel ? stored pc : stored rs1 value; o_operand_b = stored opb_sel ? stored imm : stored rs2 value; both combinational from registers.
REQ-030 o_rs2_data SHALL equal the stored rs2 value regardless of opb_sel.
REQ-031 Outputs other than o_valid and o_ready SHALL be don't-care when o_valid = 0, but SHALL NOT change unless a load or hold-bypass occurs.
REQ-032 Latency: one cycle from accepted i_valid to o_valid; throughput one instruction per cycle when i_ready = 1.

Reset
REQ-033 While i_reset = 1, the stage SHALL force o_valid = 0 and all stored fields = 0, independent of i_clk; resulting outputs are o_ready = 1, o_operand_a/b = 0, o_alu_op = 0000 (ADD), o_rd_wren = 0.
REQ-034 Reset asserted mid-hold SHALL discard the held instruction; the first accept after deassertion SHALL occur on the first rising edge with i_valid = 1.

Verification
REQ-035 Basic issue: i_valid = 1, rs1 = 5, rs2 = 7, opb_sel = 0, op = ADD, i_ready = 1 -> next cycle o_valid = 1, o_operand_a = 5, o_operand_b = 7, o_alu_op = 0000.
REQ-036 Immediate/PC select: pc = 0x100, imm = 0xFFFFFFFC, opa_sel = 1, opb_sel = 1 -> o_operand_a = 0x100, o_operand_b = 0xFFFFFFFC, o_rs2_data = i_rs2_data.
REQ-037 Load bypass: rs1_addr = 3, i_rs1_data = 1, fwd wren/addr 3/0xAA -> o_operand_a = 0xAA; same with addr 0 -> o_operand_a = 1.
REQ-038 Stall and hold bypass: hold with i_ready = 0 for 3 cycles, fwd to rs2_addr = 9 with value 0x55 in cycle 2 -> o_ready = 0 throughout the hold, o_operand_b = 0x55 from cycle 3, a new instruction is accepted on the cycle i_ready = 1.
REQ-039 Flush: o_valid = 1, i_valid = 1, i_flush = 1 -> next cycle o_valid = 0, the offered instruction never appears.
REQ-040 Async reset: assert i_reset between clock edges while o_valid = 1 -> o_valid = 0 immediately, o_ready = 1, operands = 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-entry issue register between decode and the ALU.
// Captures operands with writeback bypass on load, keeps bypassing while the
// entry stalls, and muxes PC/immediate into the ALU operands.
module alu_issue_stage (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [31:0] i_imm,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  input  logic [4:0]  i_rd_addr,
  input  logic [3:0]  i_alu_op,
  input  logic        i_opa_sel,
  input  logic        i_opb_sel,
  input  logic        i_rd_wren,
  input  logic        i_fwd_wren,
  input  logic [4:0]  i_fwd_addr,
  input  logic [31:0] i_fwd_data,
  input  logic        i_flush,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_operand_a,
  output logic [31:0] o_operand_b,
  output logic [3:0]  o_alu_op,
  output logic [31:0] o_rs2_data,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_wren
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 4;

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_rs2;
  logic [XLEN-1:0] r_imm;
  logic [RW-1:0]   r_rs1_addr;
  logic [RW-1:0]   r_rs2_addr;
  logic [RW-1:0]   r_rd_addr;
  logic [OPW-1:0]  r_alu_op;
  logic            r_opa_sel;
  logic            r_opb_sel;
  logic            r_rd_wren;

  logic            w_ready;
  logic            w_load;
  logic            w_consume;
  logic            w_hold;
  logic            w_fwd_nz;
  logic            w_ld_fwd1;
  logic            w_ld_fwd2;
  logic            w_hd_fwd1;
  logic            w_hd_fwd2;

  // Handshake and bypass match decode; x0 is never a bypass source.
  always_comb begin
    w_ready   = !r_valid || i_ready;
    w_load    = i_valid && w_ready && !i_flush;
    w_consume = r_valid && i_ready;
    w_hold    = r_valid && !i_ready && !i_flush;
    w_fwd_nz  = i_fwd_wren && (i_fwd_addr != RW'(0));
    w_ld_fwd1 = w_fwd_nz && (i_fwd_addr == i_rs1_addr);
    w_ld_fwd2 = w_fwd_nz && (i_fwd_addr == i_rs2_addr);
    w_hd_fwd1 = w_hold && w_fwd_nz && (i_fwd_addr == r_rs1_addr);
    w_hd_fwd2 = w_hold && w_fwd_nz && (i_fwd_addr == r_rs2_addr);
  end

  // Entry valid flag: flush wins, then load, then consume.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (w_load) begin
      r_valid <= 1'b1;
    end else if (w_consume) begin
      r_valid <= 1'b0;
    end
  end

  // Payload capture on load; source values also refreshed by hold bypass.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_imm      <= '0;
      r_rs1_addr <= '0;
      r_rs2_addr <= '0;
      r_rd_addr  <= '0;
      r_alu_op   <= '0;
      r_opa_sel  <= 1'b0;
      r_opb_sel  <= 1'b0;
      r_rd_wren  <= 1'b0;
    end else if (w_load) begin
      r_pc       <= i_pc;
      r_rs1      <= w_ld_fwd1 ? i_fwd_data : i_rs1_data;
      r_rs2      <= w_ld_fwd2 ? i_fwd_data : i_rs2_data;
      r_imm      <= i_imm;
      r_rs1_addr <= i_rs1_addr;
      r_rs2_addr <= i_rs2_addr;
      r_rd_addr  <= i_rd_addr;
      r_alu_op   <= i_alu_op;
      r_opa_sel  <= i_opa_sel;
      r_opb_sel  <= i_opb_sel;
      r_rd_wren  <= i_rd_wren;
    end else begin
      if (w_hd_fwd1) r_rs1 <= i_fwd_data;
      if (w_hd_fwd2) r_rs2 <= i_fwd_data;
    end
  end

  // Output view of the held entry; operand muxes sit after the registers.
  always_comb begin
    o_ready     = w_ready;
    o_valid     = r_valid;
    o_operand_a = r_opa_sel ? r_pc  : r_rs1;
    o_operand_b = r_opb_sel ? r_imm : r_rs2;
    o_alu_op    = r_alu_op;
    o_rs2_data  = r_rs2;
    o_rd_addr   = r_rd_addr;
    o_rd_wren   = r_rd_wren;
  end

endmodule
